// File: rtl/csr_wr_buffer_pkg.sv
// Shared types for the CSR write buffer.
// Architectural widths, writeback packet and buffered entry.
package csr_wr_buffer_pkg;

  localparam int SIZE_ACTIVELIST_LOG = 7;
  localparam int CSR_WIDTH_LOG = 12;
  localparam int CSR_WIDTH = 32;
  localparam int CSR_WRBUF_DEPTH = 4;

  typedef struct packed {
    logic valid;
    logic [SIZE_ACTIVELIST_LOG-1:0] alID;
    logic [CSR_WIDTH_LOG-1:0] csrWrAddr;
    logic [CSR_WIDTH-1:0] csrWrData;
    logic [CSR_WIDTH-1:0] csrWrEn;
  } wbPkt;

  typedef struct packed {
    logic [SIZE_ACTIVELIST_LOG-1:0] alID;
    logic [CSR_WIDTH_LOG-1:0] csrWrAddr;
    logic [CSR_WIDTH-1:0] csrWrData;
    logic [CSR_WIDTH-1:0] csrWrEn;
  } csrWrBufEntry;

  function automatic csrWrBufEntry toEntry(wbPkt p);
    csrWrBufEntry e;
    e.alID = p.alID;
    e.csrWrAddr = p.csrWrAddr;
    e.csrWrData = p.csrWrData;
    e.csrWrEn = p.csrWrEn;
    return e;
  endfunction

  function automatic logic isCsrWrite(wbPkt p);
    return p.valid && (|p.csrWrEn);
  endfunction

endpackage

// File: rtl/csr_wr_buffer_if.sv
// Architectural CSR write port from the buffer.
// master drives the write, slave is the CSR file.
interface csr_wr_buffer_if;
  import csr_wr_buffer_pkg::*;

  logic csrWrValid;
  logic [CSR_WIDTH_LOG-1:0] csrWrAddr;
  logic [CSR_WIDTH-1:0] csrWrData;
  logic [CSR_WIDTH-1:0] csrWrEn;

  modport master (
    output csrWrValid,
    output csrWrAddr,
    output csrWrData,
    output csrWrEn
  );

  modport slave (
    input csrWrValid,
    input csrWrAddr,
    input csrWrData,
    input csrWrEn
  );

endinterface

// File: rtl/csr_wr_fifo.sv
// In-order storage for speculative CSR writes.
// Pointers, occupancy, registered full and flush clear.
module csr_wr_fifo
  import csr_wr_buffer_pkg::*;
#(
  parameter int DEPTH = CSR_WRBUF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic enqValid,
  input  csrWrBufEntry enqEntry,
  input  logic deq,
  input  logic flush,
  output csrWrBufEntry head,
  output logic [PTR_W:0] count,
  output logic full,
  output logic empty,
  output logic overflow
);

  csrWrBufEntry mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0] countNext;
  logic enqOk;
  logic deqOk;

  assign empty = (count == '0);
  assign head = mem[rdPtr];

  // Accept/drop decisions and next occupancy.
  always_comb begin
    deqOk = deq && !empty;
    enqOk = enqValid && !flush && (!full || deqOk);
    overflow = enqValid && !flush && full && !deqOk;
    countNext = count;
    if (flush) begin
      countNext = '0;
    end else begin
      case ({enqOk, deqOk})
        2'b10: countNext = count + (PTR_W+1)'(1);
        2'b01: countNext = count - (PTR_W+1)'(1);
        default: countNext = count;
      endcase
    end
  end

  // Pointer, count and full registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full <= 1'b0;
    end else begin
      count <= countNext;
      full <= (countNext == (PTR_W+1)'(DEPTH));
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (enqOk) wrPtr <= wrPtr + PTR_W'(1);
        if (deqOk) rdPtr <= rdPtr + PTR_W'(1);
      end
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (enqOk) mem[wrPtr] <= enqEntry;
  end

endmodule

// File: rtl/csr_wr_buffer.sv
// Holds CSR writes until commit, then writes the CSR file.
// Optional alID/protocol checking: define CSR_WRBUF_CHECK_EN.
module csr_wr_buffer
  import csr_wr_buffer_pkg::*;
#(
  parameter int DEPTH = CSR_WRBUF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  input  wbPkt wbPacket_i,
  output logic full_o,
  output logic [PTR_W:0] count_o,
  input  logic commitValid_i,
  input  logic [SIZE_ACTIVELIST_LOG-1:0] commitAlID_i,
  input  logic flush_i,
  csr_wr_buffer_if.master csrWr,
  output logic error_o
);

  csrWrBufEntry head;
  logic empty;
  logic overflow;
  logic matchOk;
  logic deqOk;

  csr_wr_fifo #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .enqValid(isCsrWrite(wbPacket_i)),
    .enqEntry(toEntry(wbPacket_i)),
    .deq(deqOk),
    .flush(flush_i),
    .head(head),
    .count(count_o),
    .full(full_o),
    .empty(empty),
    .overflow(overflow)
  );

`ifdef CSR_WRBUF_CHECK_EN
  assign matchOk = (head.alID == commitAlID_i);
`else
  assign matchOk = 1'b1;
`endif

  // Commit is evaluated before any same-cycle flush clear.
  assign deqOk = commitValid_i && !empty && matchOk;

  // Launch the head entry as a one-cycle CSR write.
  always_ff @(posedge clk) begin
    if (reset) begin
      csrWr.csrWrValid <= 1'b0;
      csrWr.csrWrAddr <= '0;
      csrWr.csrWrData <= '0;
      csrWr.csrWrEn <= '0;
    end else begin
      csrWr.csrWrValid <= deqOk;
      if (deqOk) begin
        csrWr.csrWrAddr <= head.csrWrAddr;
        csrWr.csrWrData <= head.csrWrData;
        csrWr.csrWrEn <= head.csrWrEn;
      end
    end
  end

`ifdef CSR_WRBUF_CHECK_EN
  // Sticky protocol error: overflow, empty commit, alID mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_o <= 1'b0;
    end else if (overflow
                 || (commitValid_i && empty)
                 || (commitValid_i && !empty && !matchOk)) begin
      error_o <= 1'b1;
    end
  end
`else
  logic unusedChk;
  assign unusedChk = ^{commitAlID_i, head.alID, overflow};
  assign error_o = 1'b0;
`endif

endmodule
